ex_div_unit: RTL and testbench
==============================

# ex_div_unit

Iterative 32-bit integer divider in the EX stage, executing div.w, mod.w, div.wu and mod.wu. It is the producer end of the EX bypass bus consumed by the ID-stage hazard logic:
- while a division is in flight, it drives the destination register with the multi-cycle flag set, so dependent instructions are paused;
- once the result is ready, it drives the final value for forwarding.

It hands results to the EX→MEM pipeline register through a valid/ready handshake.

## Interface
Parameters:
- none; data width fixed at 32, bypass width `EX_BYPASS_LEN` (40).

Ports:
- clk  in  1  — single clock; all state updates on rising edge.
- resetn  in  1  — asynchronous, active-low reset.
- flush  in  1  — synchronous kill from exception/ertn; discards any operation in flight.
- in_valid  in  1  — a division is offered this cycle.
- in_ready  out  1  — unit can accept; a transfer occurs when in_valid & in_ready & ~flush.
- in_signed  in  1  — 1: div.w/mod.w, 0: div.wu/mod.wu.
- in_rem  in  1  — 1: return remainder, 0: return quotient.
- in_src1  in  32  — dividend.
- in_src2  in  32  — divisor.
- in_rf_waddr  in  5  — destination register.
- in_rf_we  in  1  — destination write enable.
- out_valid  out  1  — result available.
- out_ready  in  1  — downstream accepts; a transfer occurs when out_valid & out_ready.
- out_result  out  32  — final quotient or remainder.
- out_rf_waddr  out  5  — latched destination.
- out_rf_we  out  1  — latched write enable.
- ex_bypass_bus  out  40  — packed as {rf_waddr[4:0], rf_we, busy, 1'b0, result[31:0]}.

## Operation
- States:
  - IDLE: no operation held.
  - CALC: iterating; a 5-bit counter cnt counts 0..31.
  - DONE: result held.
- IDLE → CALC on accept. The accept latches:
  - in_rf_waddr, in_rf_we, in_rem;
  - sign flags: sq = signed & (src1[31]^src2[31]) and sr = signed & src1[31];
  - |src1| and |src2| when signed, raw operands otherwise.
  - cnt is cleared to 0.
- CALC performs one restoring step per cycle:
  - shift the remainder left, bringing in the next dividend MSB;
  - if the shifted value ≥ divisor, subtract the divisor and shift in quotient bit 1, else shift in 0.
  - The partial remainder is 33 bits wide; the comparison is unsigned.
- CALC → DONE after the step with cnt==31.
- Result fixup is combinational in DONE:
  - quotient = sq ? −q : q;
  - remainder = sr ? −r : r;
  - out_result selects the remainder when rem is set, the quotient otherwise.
- Divide by zero: no special case. The algorithm naturally yields q=0xFFFFFFFF and r=src1 (unsigned magnitudes), and the fixup is then applied. The bench checks this exact value.
- Signed overflow 0x80000000 / 0xFFFFFFFF: yields quotient 0x80000000, remainder 0.
- DONE → IDLE on an out transfer. If in_valid arrives in that same cycle, the unit goes DONE → CALC directly: in_ready = IDLE | (DONE & out_ready).
- flush from any state → IDLE next cycle. No accept happens in a flush cycle, even if in_valid & in_ready.
- Bypass bus fields:
  - rf_we = latched rf_we & (state≠IDLE);
  - rf_waddr = latched waddr;
  - busy = (state==CALC);
  - result = out_result in DONE, 0 otherwise.

## Timing
- Reset (asynchronous, on resetn low):
  - state=IDLE, cnt=0, all datapath registers 0;
  - out_valid=0, in_ready=1, out_result=0, out_rf_we=0, out_rf_waddr=0, ex_bypass_bus=0.
- Latency: accept at the edge ending cycle T; CALC during T+1..T+32; out_valid=1 from T+33.
- Throughput: one division per 33 cycles with out_ready held high (back-to-back via DONE→CALC).
- out_valid, out_result and out_rf_* are held stable while out_valid & ~out_ready.
- busy is high exactly in the 32 CALC cycles. rf_we on the bus is high from T+1 until the cycle after the out transfer or flush.
- A flush in cycle F gives state=IDLE, out_valid=0 and bypass rf_we=0 from F+1.
- A reset mid-operation abandons the operation without any output.

## Test plan
- Unsigned: src1=100, src2=7, quotient then remainder requests → out_result=14 and 2. out_valid rises exactly 33 cycles after accept; busy is high for 32 cycles.
- Signed: src1=0xFFFFFFF9 (−7), src2=2 → div.w=0xFFFFFFFD (−3), mod.w=0xFFFFFFFF (−1). src1=0x80000000, src2=0xFFFFFFFF → div.w=0x80000000, mod.w=0.
- Divide by zero: src1=0x12345678, src2=0, unsigned → quotient 0xFFFFFFFF, remainder 0x12345678.
- Backpressure and back-to-back:
  - hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0;
  - then out_ready=1 with in_valid=1 → next op accepted the same cycle, state CALC next cycle.
- Flush at CALC cnt=10 with in_valid=1 in the same cycle → IDLE next cycle, no accept, out_valid never asserted, bus rf_we=0.
- Bypass: in_rf_waddr=5, in_rf_we=1 → bus = {5, 1, 1, 0, 0} during CALC and {5, 1, 0, 0, result} in DONE.

Source files
------------

// File: rtl/ex_div_unit.sv
// rtl/ex_div_unit.sv - iterative 32-bit restoring divider with EX bypass bus and valid/ready output
module ex_div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_signed,
  input  logic        in_rem,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic [4:0]  in_rf_waddr,
  input  logic        in_rf_we,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [4:0]  out_rf_waddr,
  output logic        out_rf_we,
  output logic [39:0] ex_bypass_bus
);

  localparam int EX_BYPASS_LEN = 40;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [32:0] rem_q;      // partial remainder
  logic [31:0] dvd_q;      // dividend bits shift out the top, quotient bits shift in the bottom
  logic [31:0] dvs_q;      // divisor magnitude
  logic        sq_q;       // negate quotient at the end
  logic        sr_q;       // negate remainder at the end
  logic        rem_sel_q;
  logic [4:0]  waddr_q;
  logic        we_q;

  logic        accept;
  logic        out_fire;
  logic [32:0] shifted;
  logic        step_ge;
  logic [32:0] step_diff;
  logic [31:0] abs1;
  logic [31:0] abs2;
  logic [31:0] quo_fix;
  logic [31:0] rem_fix;
  logic [31:0] result;

  // Handshakes, one restoring step, operand magnitudes and the sign fixup
  always_comb begin
    in_ready  = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
    out_valid = (state_q == S_DONE);
    accept    = in_valid & in_ready & ~flush;
    out_fire  = out_valid & out_ready;

    shifted   = {rem_q[31:0], dvd_q[31]};
    step_ge   = (shifted >= {1'b0, dvs_q});
    step_diff = shifted - {1'b0, dvs_q};

    abs1 = (in_signed & in_src1[31]) ? (~in_src1 + 32'd1) : in_src1;
    abs2 = (in_signed & in_src2[31]) ? (~in_src2 + 32'd1) : in_src2;

    quo_fix = sq_q ? (~dvd_q + 32'd1) : dvd_q;
    rem_fix = sr_q ? (~rem_q[31:0] + 32'd1) : rem_q[31:0];
    result  = (state_q == S_DONE) ? (rem_sel_q ? rem_fix : quo_fix) : 32'd0;
  end

  // Next-state: flush always wins and returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_CALC;
      S_CALC: if (cnt_q == 5'd31) state_d = S_DONE;
      S_DONE: begin
        if (accept)        state_d = S_CALC;
        else if (out_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Datapath: load operands on accept, otherwise iterate while in CALC
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= 5'd0;
      rem_q     <= 33'd0;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      sq_q      <= 1'b0;
      sr_q      <= 1'b0;
      rem_sel_q <= 1'b0;
      waddr_q   <= 5'd0;
      we_q      <= 1'b0;
    end else if (accept) begin
      cnt_q     <= 5'd0;
      rem_q     <= 33'd0;
      dvd_q     <= abs1;
      dvs_q     <= abs2;
      sq_q      <= in_signed & (in_src1[31] ^ in_src2[31]);
      sr_q      <= in_signed & in_src1[31];
      rem_sel_q <= in_rem;
      waddr_q   <= in_rf_waddr;
      we_q      <= in_rf_we;
    end else if (state_q == S_CALC) begin
      cnt_q <= cnt_q + 5'd1;
      rem_q <= step_ge ? step_diff : shifted;
      dvd_q <= {dvd_q[30:0], step_ge};
    end
  end

  // Result and bypass outputs
  always_comb begin
    out_result    = result;
    out_rf_waddr  = waddr_q;
    out_rf_we     = we_q;
    ex_bypass_bus = {waddr_q, we_q & (state_q != S_IDLE), (state_q == S_CALC), 1'b0, result};
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// tb/tb_ex_div_unit.sv - scoreboard bench for ex_div_unit
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_signed;
  logic        in_rem;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic [4:0]  in_rf_waddr;
  logic        in_rf_we;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_rf_waddr;
  logic        out_rf_we;
  logic [39:0] ex_bypass_bus;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  ex_div_unit dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_signed(in_signed), .in_rem(in_rem),
    .in_src1(in_src1), .in_src2(in_src2), .in_rf_waddr(in_rf_waddr), .in_rf_we(in_rf_we),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rf_waddr(out_rf_waddr), .out_rf_we(out_rf_we), .ex_bypass_bus(ex_bypass_bus)
  );

  always #5 clk = ~clk;

  wire busy = ex_bypass_bus[33];

  // Reference: signed via 64-bit arithmetic so the overflow case is well defined
  function automatic logic [31:0] model(input bit s, input bit r, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, m;
    logic [31:0] q32, m32;
    if (b == 32'd0) return r ? a : ((s & a[31]) ? 32'h1 : 32'hFFFFFFFF);
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      m = sa % sb;
      q32 = q[31:0];
      m32 = m[31:0];
      return r ? m32 : q32;
    end
    return r ? (a % b) : (a / b);
  endfunction

  // Offer one operation and return just after the accepting edge (cycle T+1)
  task automatic send(input bit s, input bit r, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] wa, input bit we);
    int c = 0;
    in_valid = 1'b1; in_signed = s; in_rem = r; in_src1 = a; in_src2 = b;
    in_rf_waddr = wa; in_rf_we = we;
    while (!in_ready && c < 100) begin @(posedge clk); #1; c++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_q.push_back(model(s, r, a, b));
  endtask

  task automatic wait_valid(output bit ok);
    int c = 0;
    while (!out_valid && c < 100) begin @(posedge clk); #1; c++; end
    ok = out_valid;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; flush = 0; in_valid = 0; out_ready = 0;
    in_signed = 0; in_rem = 0; in_src1 = 0; in_src2 = 0; in_rf_waddr = 0; in_rf_we = 0;
    #3;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 32'd0 ||
        out_rf_we !== 1'b0 || out_rf_waddr !== 5'd0 || ex_bypass_bus !== 40'd0) begin
      n_fail++;
      $display("FAIL reset: valid=%b ready=%b res=%h we=%b wa=%0d bus=%h (want 0 1 0 0 0 0)",
               out_valid, in_ready, out_result, out_rf_we, out_rf_waddr, ex_bypass_bus);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    bit ok;
    int bad;
    logic [31:0] e;
    for (int k = 0; k < 2; k++) begin
      send(1'b0, k[0], 32'd100, 32'd7, 5'd3, 1'b1);
      bad = 0;
      for (int i = 0; i < 32; i++) begin
        if (busy !== 1'b1 || out_valid !== 1'b0) bad++;
        @(posedge clk); #1;
      end
      n_checks++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL unsigned_calc_window k=%0d: %0d bad cycles, want busy=1 valid=0 for 32", k, bad);
      end
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL unsigned_latency k=%0d: valid=%b busy=%b want 1 0 at T+33", k, out_valid, busy);
      end
      wait_valid(ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || out_result !== e) begin
        n_fail++;
        $display("FAIL unsigned_result k=%0d: got %h want %h", k, out_result, e);
      end
      consume();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL unsigned_drain k=%0d: valid=%b want 0", k, out_valid);
      end
    end
  endtask

  task automatic test_signed();
    logic [31:0] ta[4] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h80000000, 32'h80000000};
    logic [31:0] tb[4] = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] tw[4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h0};
    bit ok;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, i[0], ta[i], tb[i], 5'd4, 1'b1);
      wait_valid(ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || out_result !== e || out_result !== tw[i]) begin
        n_fail++;
        $display("FAIL signed_%0d: got %h want %h", i, out_result, tw[i]);
      end
      consume();
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] tw[2] = '{32'hFFFFFFFF, 32'h12345678};
    bit ok;
    logic [31:0] e;
    for (int i = 0; i < 2; i++) begin
      send(1'b0, i[0], 32'h12345678, 32'd0, 5'd6, 1'b1);
      wait_valid(ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || out_result !== e || out_result !== tw[i]) begin
        n_fail++;
        $display("FAIL div_zero_%0d: got %h want %h", i, out_result, tw[i]);
      end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int bad = 0;
    logic [31:0] e, held;
    send(1'b0, 1'b0, 32'd1000, 32'd3, 5'd9, 1'b1);
    wait_valid(ok);
    held = out_result;
    for (int i = 0; i < 5; i++) begin
      if (out_valid !== 1'b1 || out_result !== held || out_rf_waddr !== 5'd9 ||
          out_rf_we !== 1'b1 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!ok || bad != 0) begin
      n_fail++;
      $display("FAIL backpressure_hold: %0d unstable cycles, want 0", bad);
    end
    e = exp_q.pop_front();
    n_checks++;
    if (out_result !== e) begin
      n_fail++;
      $display("FAIL backpressure_result: got %h want %h", out_result, e);
    end
    out_ready = 1'b1;
    in_valid = 1'b1; in_signed = 1'b0; in_rem = 1'b1; in_src1 = 32'd1000; in_src2 = 32'd3;
    in_rf_waddr = 5'd10; in_rf_we = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_in_ready: got %b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    exp_q.push_back(model(1'b0, 1'b1, 32'd1000, 32'd3));
    n_checks++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_calc: busy=%b valid=%b want 1 0", busy, out_valid);
    end
    wait_valid(ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || out_result !== e || out_rf_waddr !== 5'd10) begin
      n_fail++;
      $display("FAIL b2b_result: got %h/%0d want %h/10", out_result, out_rf_waddr, e);
    end
    consume();
  endtask

  task automatic test_flush();
    int bad = 0;
    send(1'b0, 1'b0, 32'd500, 32'd5, 5'd7, 1'b1);
    void'(exp_q.pop_back());
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || ex_bypass_bus[34] !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_calc: busy=%b bus_we=%b valid=%b ready=%b want 0 0 0 1",
               busy, ex_bypass_bus[34], out_valid, in_ready);
    end
    flush = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL flush_no_accept: %0d cycles with activity, want 0", bad);
    end
  endtask

  task automatic test_bypass();
    bit ok;
    logic [31:0] e;
    send(1'b0, 1'b0, 32'd77, 32'd8, 5'd5, 1'b1);
    n_checks++;
    if (ex_bypass_bus !== {5'd5, 1'b1, 1'b1, 1'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL bypass_calc: got %h want %h", ex_bypass_bus, {5'd5, 1'b1, 1'b1, 1'b0, 32'd0});
    end
    wait_valid(ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || ex_bypass_bus !== {5'd5, 1'b1, 1'b0, 1'b0, e}) begin
      n_fail++;
      $display("FAIL bypass_done: got %h want %h", ex_bypass_bus, {5'd5, 1'b1, 1'b0, 1'b0, e});
    end
    consume();
    n_checks++;
    if (ex_bypass_bus[34] !== 1'b0 || ex_bypass_bus[31:0] !== 32'd0) begin
      n_fail++;
      $display("FAIL bypass_idle: got %h want rf_we=0 result=0", ex_bypass_bus);
    end
  endtask

  task automatic test_reset_midop();
    int bad = 0;
    send(1'b1, 1'b0, 32'd12345, 32'd11, 5'd12, 1'b1);
    void'(exp_q.pop_back());
    repeat (5) begin @(posedge clk); #1; end
    resetn = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || ex_bypass_bus !== 40'd0) begin
      n_fail++;
      $display("FAIL reset_midop: valid=%b bus=%h want 0 0", out_valid, ex_bypass_bus);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (out_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_abandon: %0d cycles valid, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_back_to_back();
    test_flush();
    test_bypass();
    test_reset_midop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
